// File: rtl/seq_pkg.sv
// Shared FSM encoding and legal parameter ranges for the test sequencer.
// No logic, no latency, no flow control.
package seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int unsigned NUM_VECTORS_MIN = 1;
    localparam int unsigned NUM_VECTORS_MAX = 65535;
    localparam int unsigned C_DELAY_MIN     = 1;
    localparam int unsigned C_DELAY_MAX     = 15;

endpackage

// File: rtl/seq_delay_line.sv
// Delays a single valid bit by DEPTH cycles; flush zeroes every stage.
// Latency DEPTH cycles; no backpressure, one bit shifts per clock.
module seq_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else if (flush) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/test_sequencer.sv
// Run controller for random-compare testing; SEQ_STOP_ON_ERR_EN ends a run on the first error.
// stim_en follows state combinationally, cvalid lags it by C_DELAY; start is ignored while busy.
module test_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_VECTORS = 1000,
    parameter int C_DELAY     = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic                 cerr,
    output logic                 stim_en,
    output logic                 cvalid,
    output logic [CNT_WIDTH-1:0] vec_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    state_t                 state;
    logic [15:0]            issued;
    logic [3:0]             drain_cnt;
    logic                   err_hit;
    logic                   stop_now;
    logic [CNT_WIDTH-1:0]   err_next;

    assign stim_en = (state == ST_RUN);
    assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
    assign err_hit = cvalid && cerr;
    assign err_next = (err_hit && !(&err_count)) ? err_count + 1'b1 : err_count;

`ifdef SEQ_STOP_ON_ERR_EN
    assign stop_now = err_hit && busy;
`else
    assign stop_now = 1'b0;
`endif

    seq_delay_line #(
        .DEPTH (C_DELAY)
    ) u_valid_dly (
        .clk   (Clk),
        .rst   (Rst),
        .flush (stop_now),
        .din   (stim_en),
        .dout  (cvalid)
    );

    // Run length is tracked by 'issued' (full 16 bits) so a narrow vec_count can saturate safely.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            issued    <= '0;
            drain_cnt <= '0;
            vec_count <= '0;
            err_count <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        issued    <= '0;
                        vec_count <= '0;
                        err_count <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    issued    <= issued + 16'd1;
                    err_count <= err_next;
                    if (!(&vec_count)) begin
                        vec_count <= vec_count + 1'b1;
                    end
                    if (stop_now) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (issued == 16'(NUM_VECTORS - 1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    err_count <= err_next;
                    if (stop_now) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (drain_cnt == 4'(C_DELAY - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
